// File: rtl/ssd_scan_ctrl.sv
// Multiplexed scan controller for a common-anode 7-segment display.
// One shared nibble output, per-slot guard blanking, leading-zero suppression and frame-synchronous data commit.
module ssd_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                    ssd_scan_ctrl_port_clk,
   input  logic                    ssd_scan_ctrl_port_rst,
   input  logic                    ssd_scan_ctrl_port_load,
   input  logic [4*NUM_DIGITS-1:0] ssd_scan_ctrl_port_data,
   input  logic                    ssd_scan_ctrl_port_lz_en,
   output logic [3:0]              ssd_scan_ctrl_port_digit,
   output logic [NUM_DIGITS-1:0]   ssd_scan_ctrl_port_an,
   output logic                    ssd_scan_ctrl_port_ack,
   output logic                    ssd_scan_ctrl_port_frame
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] C_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] C_BLAST = CW'(BLANK_CYCLES - 1);
   localparam logic [IW-1:0] I_LAST  = IW'(NUM_DIGITS - 1);

   typedef enum logic {ST_BLANK, ST_SHOW} state_t;

   state_t                       r_state, w_state_nxt;
   logic [CW-1:0]                r_cnt, w_cnt_nxt;
   logic [IW-1:0]                r_idx, w_idx_nxt;
   logic [NUM_DIGITS-1:0][3:0]   r_shown, r_pend, w_shown_nxt;
   logic                         r_pend_vld, r_lz, w_lz_nxt;
   logic                         w_commit, w_blank, w_frame_nxt;
   logic [NUM_DIGITS-1:0]        w_zup, w_an_nxt, r_an;
   logic [3:0]                   r_digit;
   logic                         r_ack, r_frame;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_idx_nxt   = r_idx;
      case (r_state)
         ST_BLANK: if (r_cnt == C_BLAST) w_state_nxt = ST_SHOW;
         ST_SHOW: if (r_cnt == C_LAST) begin
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = '0;
            w_idx_nxt   = (r_idx == I_LAST) ? '0 : r_idx + 1'b1;
         end
         default: w_state_nxt = ST_BLANK;
      endcase
   end

   // Outputs are registered from next-state values so they line up with the state they describe.
   assign w_frame_nxt = (w_state_nxt == ST_SHOW) && (w_cnt_nxt == C_LAST) && (w_idx_nxt == I_LAST);
   assign w_commit    = r_frame & r_pend_vld;
   assign w_shown_nxt = w_commit ? r_pend : r_shown;
   assign w_lz_nxt    = (w_cnt_nxt == '0) ? ssd_scan_ctrl_port_lz_en : r_lz;

   // w_zup[i]: nibble i and everything above it are zero.
   always_comb begin
      w_zup = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         logic v_z;
         v_z = 1'b1;
         for (int j = i; j < NUM_DIGITS; j++) v_z = v_z & (w_shown_nxt[j] == 4'd0);
         w_zup[i] = v_z;
      end
   end

   assign w_blank = w_lz_nxt && (w_idx_nxt != '0) && w_zup[w_idx_nxt];

   always_comb begin
      w_an_nxt = '1;
      if (w_state_nxt == ST_SHOW && !w_blank)
         w_an_nxt = ~(NUM_DIGITS'(1) << w_idx_nxt);
   end

   always_ff @(posedge ssd_scan_ctrl_port_clk or posedge ssd_scan_ctrl_port_rst) begin
      if (ssd_scan_ctrl_port_rst) begin
         r_state    <= ST_BLANK;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_shown    <= '0;
         r_pend     <= '0;
         r_pend_vld <= 1'b0;
         r_lz       <= 1'b0;
         r_an       <= '1;
         r_digit    <= 4'd0;
         r_ack      <= 1'b0;
         r_frame    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_shown <= w_shown_nxt;
         r_lz    <= w_lz_nxt;
         r_an    <= w_an_nxt;
         r_digit <= w_shown_nxt[w_idx_nxt];
         r_ack   <= w_commit;
         r_frame <= w_frame_nxt;
         // A load on the frame cycle lands after the commit and waits for the next frame.
         if (ssd_scan_ctrl_port_load) begin
            r_pend     <= ssd_scan_ctrl_port_data;
            r_pend_vld <= 1'b1;
         end else if (w_commit) begin
            r_pend_vld <= 1'b0;
         end
      end
   end

   assign ssd_scan_ctrl_port_digit = r_digit;
   assign ssd_scan_ctrl_port_an    = r_an;
   assign ssd_scan_ctrl_port_ack   = r_ack;
   assign ssd_scan_ctrl_port_frame = r_frame;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl: a cycle-indexed reference model pushes expected outputs,
// a negedge monitor pops and compares them.
module tb_ssd_scan_ctrl;
   localparam int N = 4, RD = 8, BL = 2, FR = N * RD;

   logic        clk = 1'b0, rst = 1'b0, load = 1'b0, lz = 1'b0;
   logic [15:0] data = '0;
   logic [3:0]  digit, an;
   logic        ack, frame;

   ssd_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
      .ssd_scan_ctrl_port_clk  (clk),
      .ssd_scan_ctrl_port_rst  (rst),
      .ssd_scan_ctrl_port_load (load),
      .ssd_scan_ctrl_port_data (data),
      .ssd_scan_ctrl_port_lz_en(lz),
      .ssd_scan_ctrl_port_digit(digit),
      .ssd_scan_ctrl_port_an   (an),
      .ssd_scan_ctrl_port_ack  (ack),
      .ssd_scan_ctrl_port_frame(frame)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [3:0] an;
      logic [3:0] digit;
      logic       frame;
      logic       ack;
   } exp_t;

   exp_t q[$];
   int   vectors = 0, miscompares = 0, n_push = 0, n_pop = 0;

   // Reference model: cycle number since reset plus displayed / pending words.
   int          t = 0;
   logic [15:0] m_shown = '0, m_pend = '0;
   bit          m_pvld = 0, m_ack = 0, m_lz = 0;

   function automatic exp_t expect_now();
      exp_t e;
      int   pos, idx;
      bit   blank;
      pos   = t % RD;
      idx   = (t / RD) % N;
      blank = m_lz && (idx > 0) && ((m_shown >> (4 * idx)) == 16'd0);
      e.cyc   = t;
      e.an    = (pos >= BL && !blank) ? ~(4'b0001 << idx) : 4'hF;
      e.digit = m_shown[4*idx +: 4];
      e.frame = ((t % FR) == FR - 1);
      e.ack   = m_ack;
      return e;
   endfunction

   task automatic cyc(input bit ld, input logic [15:0] d, input bit lzv);
      exp_t e;
      bit   commit;
      e = expect_now();
      q.push_back(e);
      n_push++;
      load = ld;
      data = d;
      lz   = lzv;
      commit = e.frame && m_pvld;
      m_ack  = commit;
      if (commit) begin m_shown = m_pend; m_pvld = 0; end
      if (ld) begin m_pend = d; m_pvld = 1; end
      if (t % RD == RD - 1) m_lz = lzv;
      t++;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      load = 1'b0;
      #1;
      vectors++;
      if (an !== 4'hF || digit !== 4'd0 || ack !== 1'b0 || frame !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_values: an=%b digit=%h ack=%b frame=%b, want an=1111 digit=0 ack=0 frame=0",
                  an, digit, ack, frame);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      t = 0; m_shown = '0; m_pend = '0; m_pvld = 0; m_ack = 0; m_lz = 0;
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         n_pop++;
         vectors++;
         if (an !== e.an || digit !== e.digit || frame !== e.frame || ack !== e.ack) begin
            miscompares++;
            $display("FAIL cycle %0d: an=%b digit=%h frame=%b ack=%b, want an=%b digit=%h frame=%b ack=%b",
                     e.cyc, an, digit, frame, ack, e.an, e.digit, e.frame, e.ack);
         end
      end
   end

   initial begin
      bit          lzr;
      logic [15:0] rd;
      #2;
      do_reset();
      // scan timing and first commit
      repeat (64) cyc(t == 5, 16'h1234, 1'b0);
      // back-to-back loads, only the last one shown, then leading-zero blanking
      repeat (64) cyc(t == 67 || t == 84, (t == 67) ? 16'hAAAA : 16'h0042, t >= 90);
      // all-zero word with blanking: only digit 0 lit
      repeat (64) cyc(t == 130, 16'h0000, 1'b1);
      // load on the frame cycle itself commits one frame later
      repeat (96) cyc(t == 223, 16'h5678, 1'b1);
      // randomized loads, data with varying leading zeros, lz toggling
      lzr = 1'b1;
      repeat (800) begin
         rd = 16'($urandom);
         case ($urandom_range(0, 4))
            0: rd = rd & 16'h000F;
            1: rd = rd & 16'h00FF;
            2: rd = rd & 16'h0FFF;
            default: ;
         endcase
         if ($urandom_range(0, 29) == 0) lzr = ~lzr;
         cyc(($urandom_range(0, 15) == 0) || (t % FR == FR - 1 && $urandom_range(0, 1) == 1), rd, lzr);
      end
      // async reset mid-SHOW with a pending load that must be discarded
      do_reset();
      repeat (13) cyc(t == 5, 16'h9ABC, 1'b0);
      do_reset();
      repeat (80) cyc(1'b0, 16'h0000, 1'b0);
      load = 1'b0;
      @(negedge clk); #1;
      vectors++;
      if (n_push != n_pop || q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: popped=%0d, want %0d", n_pop, n_push);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time bound");
      $fatal(1, "timeout");
   end
endmodule
